// File: rtl/rs232_pkg.sv
// Shared RS232 definitions: byte width and transmit-buffer issue states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rs232_pkg;

    localparam int BYTE_W = 8;

    // Issue sequencer states; IDLE must be the all-zero encoding.
    typedef enum logic [1:0] {
        TXB_IDLE  = 2'd0,
        TXB_ISSUE = 2'd1,
        TXB_GUARD = 2'd2
    } txb_state_e;

endpackage

// File: rtl/rs232_fifo_mem.sv
// Dual-port Slots x BYTE_W register array: synchronous write, asynchronous read.
// Latency: write visible to the read port the cycle after the write edge.
// Backpressure: none; the owner guards writes against overrun.
//
// Ports:
//   clk_i    - system clock
//   we_i     - write enable, stores wdata_i at waddr_i on the rising edge
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - combinational read of the addressed entry
module rs232_fifo_mem
    import rs232_pkg::*;
#(
    parameter int Slots = 16,
    localparam int AW   = $clog2(Slots)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [BYTE_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [BYTE_W-1:0] rdata_o
);

    // Storage is deliberately unreset: only entries between the pointers are ever read.
    logic [BYTE_W-1:0] mem_q [Slots];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rs232_txbuf.sv
// Byte FIFO feeding the RS232 transmitter with one-cycle start pulses plus a guard cycle.
// Latency: byte written on edge N into an idle, empty buffer pulses tx_start during cycle N+2.
// Backpressure: issue waits for tx_rdy; writes while full are dropped and flagged in ovf.
//
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   wr, wr_data       - processor-side write strobe and byte
//   clr_ovf           - clears the sticky overflow flag (a same-cycle drop wins)
//   full, empty, count- occupancy status (full/empty decoded from count)
//   ovf               - sticky flag, a write was dropped
//   tx_rdy            - transmitter idle
//   tx_start, tx_data - one-cycle issue request and its byte (held between issues)
module rs232_txbuf
    import rs232_pkg::*;
#(
    parameter int Slots = 16,
    localparam int AW   = $clog2(Slots),
    localparam int CW   = $clog2(Slots) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              clr_ovf,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    output logic              ovf,
    input  logic              tx_rdy,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data
);

    txb_state_e        state_q;
    logic              tx_start_q;
    logic [BYTE_W-1:0] tx_data_q;

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;

    logic              wr_acc;
    logic              wr_drop;
    logic              pop;
    logic [BYTE_W-1:0] rd_data;

    assign full  = (count_q == CW'(Slots));
    assign empty = (count_q == '0);

    // Full is judged on the pre-pop count, so a same-cycle pop never rescues a write.
    assign wr_acc  = wr && !full;
    assign wr_drop = wr && full;
    assign pop     = (state_q == TXB_IDLE) && tx_rdy && !empty;

    rs232_fifo_mem #(
        .Slots (Slots)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        // Push and pop together leave count alone; the pop reads the older entry.
        unique case ({wr_acc, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (wr_drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Issue sequencer. GUARD ignores tx_rdy for one cycle because the transmitter
    // may still show ready in the cycle after it saw tx_start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= TXB_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            unique case (state_q)
                TXB_IDLE: begin
                    tx_start_q <= 1'b0;
                    if (pop) begin
                        tx_data_q  <= rd_data;
                        tx_start_q <= 1'b1;
                        state_q    <= TXB_ISSUE;
                    end
                end
                TXB_ISSUE: begin
                    tx_start_q <= 1'b0;
                    state_q    <= TXB_GUARD;
                end
                TXB_GUARD: begin
                    tx_start_q <= 1'b0;
                    state_q    <= TXB_IDLE;
                end
                default: begin
                    tx_start_q <= 1'b0;
                    state_q    <= TXB_IDLE;
                end
            endcase
        end
    end

    assign count    = count_q;
    assign ovf      = ovf_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_rs232_txbuf.sv
module tb_rs232_txbuf;

    localparam int SLOTS = 16;
    localparam int CW    = $clog2(SLOTS) + 1;

    logic          clk;
    logic          rst_n;
    logic          wr;
    logic [7:0]    wr_data;
    logic          clr_ovf;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          ovf;
    logic          tx_rdy;
    logic          tx_start;
    logic [7:0]    tx_data;

    // Transmitter model controls
    logic          txm_en;
    logic          tx_rdy_man;
    int            busy;

    assign tx_rdy = txm_en ? (busy == 0) : tx_rdy_man;

    rs232_txbuf #(.Slots(SLOTS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr       (wr),
        .wr_data  (wr_data),
        .clr_ovf  (clr_ovf),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .ovf      (ovf),
        .tx_rdy   (tx_rdy),
        .tx_start (tx_start),
        .tx_data  (tx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sb_q[$];
    int         n_pulse = 0;
    int         cyc     = 0;
    int         last_pulse = -100;
    logic       prev_start = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: every start pulse must match the oldest expected byte.
    always @(negedge clk) begin
        cyc++;
        if (tx_start) begin
            n_pulse++;
            chk("pulse_width", {31'd0, prev_start}, 32'd0);
            chk("pulse_gap_ge3", {31'd0, (cyc - last_pulse) >= 3}, 32'd1);
            last_pulse = cyc;
            if (sb_q.size() == 0) begin
                chk("spurious_start", 32'd1, 32'd0);
            end else begin
                logic [7:0] e;
                e = sb_q.pop_front();
                chk("tx_data", {24'd0, tx_data}, {24'd0, e});
            end
            if (txm_en) busy = 40;
        end else if (busy > 0) begin
            busy--;
        end
        prev_start = tx_start;
    end

    // Drive one write across the next rising edge; returns at the following negedge.
    task automatic do_write(input logic [7:0] b, input bit accepted);
        wr      = 1'b1;
        wr_data = b;
        if (accepted) sb_q.push_back(b);
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_done", sb_q.size(), 32'd0);
        repeat (4) @(negedge clk);
        chk("drain_count", {27'd0, count}, 32'd0);
        chk("drain_empty", {31'd0, empty}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst_n      = 1'b0;
        wr         = 1'b1;
        wr_data    = 8'hFF;
        clr_ovf    = 1'b0;
        txm_en     = 1'b0;
        tx_rdy_man = 1'b1;
        busy       = 0;

        // Reset with a write held active
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wr    = 1'b0;
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_no_pulse", n_pulse, 32'd0);

        // Single byte latency
        do_write(8'hA5, 1'b1);
        chk("single_cnt_n1", {27'd0, count}, 32'd1);
        chk("single_start_n1", {31'd0, tx_start}, 32'd0);
        @(negedge clk);
        chk("single_start_n2", {31'd0, tx_start}, 32'd1);
        chk("single_data_n2", {24'd0, tx_data}, 32'hA5);
        chk("single_cnt_n2", {27'd0, count}, 32'd0);
        @(negedge clk);
        chk("single_start_n3", {31'd0, tx_start}, 32'd0);
        chk("single_hold_n3", {24'd0, tx_data}, 32'hA5);
        repeat (3) @(negedge clk);

        // Burst against a slow transmitter
        p0     = n_pulse;
        txm_en = 1'b1;
        for (int i = 1; i <= 5; i++) do_write(8'(i), 1'b1);
        wait_drain(400);
        chk("burst_pulses", n_pulse - p0, 32'd5);
        txm_en = 1'b0;
        busy   = 0;

        // Fill, overflow, clear
        tx_rdy_man = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) do_write(8'h10 + 8'(i), 1'b1);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_ovf_clean", {31'd0, ovf}, 32'd0);
        do_write(8'hEE, 1'b0);
        chk("ovf_full", {31'd0, full}, 32'd1);
        chk("ovf_count", {27'd0, count}, 32'd16);
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_clr", {31'd0, ovf}, 32'd0);
        clr_ovf = 1'b1;
        do_write(8'hEF, 1'b0);
        clr_ovf = 1'b0;
        chk("ovf_set_wins", {31'd0, ovf}, 32'd1);
        chk("ovf_count2", {27'd0, count}, 32'd16);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        tx_rdy_man = 1'b1;
        wait_drain(16 * 3 + 20);
        chk("drain_ovf", {31'd0, ovf}, 32'd0);

        // Push and pop in the same cycle at count==1
        tx_rdy_man = 1'b0;
        do_write(8'h77, 1'b1);
        chk("pp_cnt_before", {27'd0, count}, 32'd1);
        tx_rdy_man = 1'b1;
        do_write(8'h3C, 1'b1);
        chk("pp_cnt_after", {27'd0, count}, 32'd1);
        chk("pp_first_out", {24'd0, tx_data}, 32'h77);
        wait_drain(20);

        // Reset in the middle of a burst
        tx_rdy_man = 1'b0;
        for (int i = 0; i < 4; i++) do_write(8'h40 + 8'(i), 1'b1);
        tx_rdy_man = 1'b1;
        @(negedge clk);
        chk("mid_issue", {31'd0, tx_start}, 32'd1);
        #1;
        rst_n      = 1'b0;
        tx_rdy_man = 1'b0;
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_start_supp", {31'd0, tx_start}, 32'd0);
        chk("mid_count", {27'd0, count}, 32'd0);
        chk("mid_empty", {31'd0, empty}, 32'd1);
        p0         = n_pulse;
        tx_rdy_man = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_no_pulse", n_pulse - p0, 32'd0);

        // Wrap the pointers after reset
        for (int i = 0; i < 20; i++) do_write(8'h80 + 8'(i), 1'b1);
        chk("wrap_ovf", {31'd0, ovf}, 32'd0);
        wait_drain(100);
        chk("wrap_pulses", n_pulse - p0, 32'd20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
